melody_sequencer: RTL and testbench



---
 rtl/music_pkg.sv | 51 +++++
 rtl/song_rom.sv | 32 +++
 rtl/melody_sequencer.sv | 159 +++++++++++++++
 tb/tb_melody_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared types, field widths, song layout and tone decode for the melody sequencer.
package music_pkg;

  localparam int unsigned TONE_WIDTH = 14;
  localparam int unsigned CODE_WIDTH = 4;
  localparam int unsigned DUR_WIDTH  = 3;
  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned N_SONGS    = 2;
  localparam int unsigned SEL_WIDTH  = 1;
  localparam int unsigned WORD_WIDTH = CODE_WIDTH + DUR_WIDTH;
  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CODE_WIDTH-1:0] REST_CODE = '0;
  localparam logic [CODE_WIDTH-1:0] END_CODE  = '1;

  // Start address of each song inside the shared ROM, indexed by song number.
  localparam logic [N_SONGS-1:0][ADDR_WIDTH-1:0] SONG_BASE = {
    ADDR_WIDTH'(64),
    ADDR_WIDTH'(0)
  };

  typedef struct packed {
    logic [CODE_WIDTH-1:0] code;
    logic [DUR_WIDTH-1:0]  dur;
  } note_word_t;

  function automatic note_word_t mk_word(input logic [CODE_WIDTH-1:0] code,
                                         input logic [DUR_WIDTH-1:0]  dur);
    note_word_t w;
    w.code = code;
    w.dur  = dur;
    return w;
  endfunction

  // Codes 1..TONE_WIDTH light one tone line; rest, END and unused codes are silent.
  function automatic logic [TONE_WIDTH-1:0] code2tone(input logic [CODE_WIDTH-1:0] code);
    logic [TONE_WIDTH-1:0] t;
    t = '0;
    if ((code != REST_CODE) && (32'(code) <= TONE_WIDTH)) begin
      t = TONE_WIDTH'(1) << (code - CODE_WIDTH'(1));
    end
    return t;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Combinational case-ROM holding every song; unlisted addresses read as a one-tick rest.
module song_rom
  import music_pkg::*;
#(
  parameter int unsigned AW = ADDR_WIDTH,
  parameter int unsigned WW = WORD_WIDTH
) (
  input  logic [AW-1:0] addr,
  output logic [WW-1:0] data
);

  note_word_t word;

  always_comb begin
    word = mk_word(REST_CODE, 3'd0);
    case (addr)
      // song 0
      AW'(0):  word = mk_word(4'd6,  3'd1);
      AW'(1):  word = mk_word(4'd0,  3'd0);
      AW'(2):  word = mk_word(4'd8,  3'd2);
      AW'(3):  word = mk_word(END_CODE, 3'd0);
      // song 1
      AW'(64): word = mk_word(4'd1,  3'd0);
      AW'(65): word = mk_word(4'd3,  3'd1);
      AW'(66): word = mk_word(4'd14, 3'd0);
      AW'(67): word = mk_word(END_CODE, 3'd0);
      default: word = mk_word(REST_CODE, 3'd0);
    endcase
    data = WW'(word);
  end

endmodule

// File: rtl/melody_sequencer.sv
// Song-ROM melody player: per-note durations, pause/mute, looping, song select and manual-key bypass.
module melody_sequencer
  import music_pkg::*;
#(
  parameter int unsigned TONE_W    = TONE_WIDTH,
  parameter int unsigned CODE_W    = CODE_WIDTH,
  parameter int unsigned DUR_W     = DUR_WIDTH,
  parameter int unsigned ADDR_W    = ADDR_WIDTH,
  parameter int unsigned NUM_SONGS = N_SONGS,
  parameter int unsigned SEL_W     = SEL_WIDTH
) (
  input  logic              clk_4HZ,
  input  logic              rst,
  input  logic              auto,
  input  logic [TONE_W-1:0] key,
  input  logic              start,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [SEL_W-1:0]  song_sel,
  output logic [TONE_W-1:0] tone,
  output logic [ADDR_W-1:0] note_idx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WORD_W = CODE_W + DUR_W;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [TONE_W-1:0]   note_q, note_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [SEL_W-1:0]    sel_eff;
  logic [ADDR_W-1:0]   base_sel;
  logic [ADDR_W-1:0]   rom_addr;
  logic [WORD_W-1:0]   rom_word;
  logic [CODE_W-1:0]   rom_code;
  logic [DUR_W-1:0]    rom_dur;
  logic [TONE_W-1:0]   rom_tone;

  // Out-of-range song numbers fall back to song 0.
  assign sel_eff  = (32'(song_sel) < NUM_SONGS) ? song_sel : '0;
  assign base_sel = SONG_BASE[sel_eff];

  // A start inside PLAY must fetch the new song's first word, not the word at ptr.
  assign rom_addr = ((state_q == ST_PLAY) && !start) ? ptr_q : base_sel;

  song_rom #(
    .AW (ADDR_W),
    .WW (WORD_W)
  ) u_rom (
    .addr (rom_addr),
    .data (rom_word)
  );

  assign rom_code = rom_word[WORD_W-1:DUR_W];
  assign rom_dur  = rom_word[DUR_W-1:0];
  assign rom_tone = TONE_W'(code2tone(rom_code));

  // Next-state, pointer, duration and note logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    dur_d   = dur_q;
    note_d  = note_q;

    case (state_q)
      ST_IDLE: begin
        if (auto && start) begin
          state_d = ST_PLAY;
          sel_d   = sel_eff;
          note_d  = rom_tone;
          dur_d   = rom_dur;
          ptr_d   = ADDR_W'(base_sel + ADDR_W'(1));
        end
      end

      ST_PLAY: begin
        if (!auto) begin
          state_d = ST_IDLE;
          note_d  = '0;
        end else if (start) begin
          sel_d   = sel_eff;
          note_d  = rom_tone;
          dur_d   = rom_dur;
          ptr_d   = ADDR_W'(base_sel + ADDR_W'(1));
        end else if (pause) begin
          // Paused: every register holds, output is muted by the tone mux.
          state_d = ST_PLAY;
        end else if (dur_q != '0) begin
          dur_d = dur_q - DUR_W'(1);
        end else if (rom_code == CODE_W'(END_CODE)) begin
          note_d = '0;
          if (loop_en) begin
            ptr_d = SONG_BASE[sel_q];
            dur_d = '0;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          note_d = rom_tone;
          dur_d  = rom_dur;
          ptr_d  = ptr_q + ADDR_W'(1);
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d = ST_PLAY;
          sel_d   = sel_eff;
          note_d  = rom_tone;
          dur_d   = rom_dur;
          ptr_d   = ADDR_W'(base_sel + ADDR_W'(1));
        end else if (!auto) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        note_d  = '0;
      end
    endcase

    busy_d = (state_d == ST_PLAY);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_4HZ or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      dur_q   <= '0;
      note_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      dur_q   <= dur_d;
      note_q  <= note_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Manual keys bypass the sequencer with no latency.
  assign tone     = auto ? (pause ? '0 : note_q) : key;
  assign note_idx = ptr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: expected per-tick outputs are queued with the stimulus.
module tb_melody_sequencer;

  localparam int unsigned TW = 14;
  localparam int unsigned AW = 7;

  typedef struct packed {
    logic [TW-1:0] tone;
    logic [AW-1:0] idx;
    logic          busy;
    logic          done;
  } exp_t;

  logic          clk_4HZ;
  logic          rst;
  logic          auto;
  logic [TW-1:0] key;
  logic          start;
  logic          pause;
  logic          loop_en;
  logic [0:0]    song_sel;
  logic [TW-1:0] tone;
  logic [AW-1:0] note_idx;
  logic          busy;
  logic          done;

  int   n_cmp;
  int   n_err;
  exp_t sb[$];

  melody_sequencer dut (
    .clk_4HZ  (clk_4HZ),
    .rst      (rst),
    .auto     (auto),
    .key      (key),
    .start    (start),
    .pause    (pause),
    .loop_en  (loop_en),
    .song_sel (song_sel),
    .tone     (tone),
    .note_idx (note_idx),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk_4HZ = 1'b0;
    forever #5 clk_4HZ = ~clk_4HZ;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_4HZ);
    @(negedge clk_4HZ);
  endtask

  function automatic void push(input logic [TW-1:0] t, input logic [AW-1:0] i,
                               input logic b, input logic d);
    exp_t e;
    e.tone = t;
    e.idx  = i;
    e.busy = b;
    e.done = d;
    sb.push_back(e);
  endfunction

  task automatic go_idle();
    auto = 1'b0; start = 1'b0; pause = 1'b0; loop_en = 1'b0; key = '0; song_sel = 1'b0;
    tick();
    auto = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    exp_t o;
    rst = 1'b0; auto = 1'b1; key = '0; start = 1'b0; pause = 1'b0; loop_en = 1'b0; song_sel = 1'b0;
    @(negedge clk_4HZ);
    o = exp_t'({tone, note_idx, busy, done});
    n_cmp++;
    if (o !== exp_t'(0)) begin
      n_err++;
      $display("FAIL reset_state: got %h need %h", o, exp_t'(0));
    end
    rst = 1'b1;
  endtask

  task automatic test_bypass();
    logic [TW-1:0] keys [3];
    exp_t o, e;
    keys = '{14'h0010, 14'h2000, 14'h0001};
    auto = 1'b0;
    foreach (keys[k]) begin
      key = keys[k];
      #1;
      n_cmp++;
      if (tone !== keys[k]) begin
        n_err++;
        $display("FAIL bypass_same_cycle[%0d]: got tone %h need %h", k, tone, keys[k]);
      end
    end
    key = 14'h0010;
    start = 1'b1;
    tick();
    push(14'h0010, '0, 1'b0, 1'b0);
    e = sb.pop_front();
    o = exp_t'({tone, note_idx, busy, done});
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL bypass_stays_idle: got %h need %h", o, e);
    end
    start = 1'b0;
    // Dropping auto mid-song returns to IDLE and hands tone to the keys at once.
    auto = 1'b1; key = '0; start = 1'b1;
    tick();
    start = 1'b0;
    auto = 1'b0; key = 14'h0040;
    #1;
    n_cmp++;
    if (tone !== 14'h0040) begin
      n_err++;
      $display("FAIL bypass_midsong_tone: got %h need %h", tone, 14'h0040);
    end
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL bypass_midsong_state: got busy,done %b need 00", {busy, done});
    end
    go_idle();
  endtask

  task automatic test_single_play();
    exp_t o, e;
    start = 1'b1; loop_en = 1'b0; song_sel = 1'b0;
    push(14'h0020, 7'd1, 1'b1, 1'b0);
    push(14'h0020, 7'd1, 1'b1, 1'b0);
    push(14'h0000, 7'd2, 1'b1, 1'b0);
    push(14'h0080, 7'd3, 1'b1, 1'b0);
    push(14'h0080, 7'd3, 1'b1, 1'b0);
    push(14'h0080, 7'd3, 1'b1, 1'b0);
    push(14'h0000, 7'd3, 1'b0, 1'b1);
    push(14'h0000, 7'd3, 1'b0, 1'b1);
    for (int s = 0; s < 8; s++) begin
      tick();
      start = 1'b0;
      e = sb.pop_front();
      o = exp_t'({tone, note_idx, busy, done});
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL single_play step %0d: got %h need %h", s, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t o, e;
    start = 1'b1;
    push(14'h0020, 7'd1, 1'b1, 1'b0);
    push(14'h0020, 7'd1, 1'b1, 1'b0);
    push(14'h0000, 7'd2, 1'b1, 1'b0);
    for (int s = 0; s < 3; s++) begin
      tick();
      start = 1'b0;
      e = sb.pop_front();
      o = exp_t'({tone, note_idx, busy, done});
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL back_to_back step %0d: got %h need %h", s, o, e);
      end
    end
    go_idle();
  endtask

  task automatic test_loop();
    exp_t o, e;
    start = 1'b1; loop_en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      push(14'h0020, 7'd1, 1'b1, 1'b0);
      push(14'h0020, 7'd1, 1'b1, 1'b0);
      push(14'h0000, 7'd2, 1'b1, 1'b0);
      push(14'h0080, 7'd3, 1'b1, 1'b0);
      push(14'h0080, 7'd3, 1'b1, 1'b0);
      push(14'h0080, 7'd3, 1'b1, 1'b0);
      push(14'h0000, 7'd0, 1'b1, 1'b0);
    end
    for (int s = 0; s < 21; s++) begin
      tick();
      start = 1'b0;
      e = sb.pop_front();
      o = exp_t'({tone, note_idx, busy, done});
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL loop step %0d: got %h need %h", s, o, e);
      end
    end
    go_idle();
  endtask

  task automatic test_pause();
    exp_t o, e;
    logic pz [10];
    pz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    start = 1'b1; loop_en = 1'b0;
    push(14'h0020, 7'd1, 1'b1, 1'b0);
    push(14'h0020, 7'd1, 1'b1, 1'b0);
    push(14'h0000, 7'd2, 1'b1, 1'b0);
    push(14'h0080, 7'd3, 1'b1, 1'b0);
    push(14'h0000, 7'd3, 1'b1, 1'b0);
    push(14'h0000, 7'd3, 1'b1, 1'b0);
    push(14'h0000, 7'd3, 1'b1, 1'b0);
    push(14'h0080, 7'd3, 1'b1, 1'b0);
    push(14'h0080, 7'd3, 1'b1, 1'b0);
    push(14'h0000, 7'd3, 1'b0, 1'b1);
    for (int s = 0; s < 10; s++) begin
      pause = pz[s];
      tick();
      start = 1'b0;
      e = sb.pop_front();
      o = exp_t'({tone, note_idx, busy, done});
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL pause step %0d: got %h need %h", s, o, e);
      end
    end
    go_idle();
  endtask

  task automatic test_restart_sel();
    exp_t o, e;
    logic st [8];
    logic sl [8];
    st = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    sl = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    loop_en = 1'b0;
    push(14'h0020, 7'd1,  1'b1, 1'b0);
    push(14'h0020, 7'd1,  1'b1, 1'b0);
    push(14'h0000, 7'd2,  1'b1, 1'b0);
    push(14'h0001, 7'd65, 1'b1, 1'b0);
    push(14'h0004, 7'd66, 1'b1, 1'b0);
    push(14'h0004, 7'd66, 1'b1, 1'b0);
    push(14'h2000, 7'd67, 1'b1, 1'b0);
    push(14'h0000, 7'd67, 1'b0, 1'b1);
    for (int s = 0; s < 8; s++) begin
      start = st[s];
      song_sel = sl[s];
      tick();
      e = sb.pop_front();
      o = exp_t'({tone, note_idx, busy, done});
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL restart_sel step %0d: got %h need %h", s, o, e);
      end
    end
    go_idle();
  endtask

  task automatic test_reset_midnote();
    exp_t o;
    start = 1'b1; loop_en = 1'b1; song_sel = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    o = exp_t'({tone, note_idx, busy, done});
    n_cmp++;
    if (o !== exp_t'(0)) begin
      n_err++;
      $display("FAIL reset_midnote_async: got %h need %h", o, exp_t'(0));
    end
    tick();
    o = exp_t'({tone, note_idx, busy, done});
    n_cmp++;
    if (o !== exp_t'(0)) begin
      n_err++;
      $display("FAIL reset_midnote_held: got %h need %h", o, exp_t'(0));
    end
    rst = 1'b1;
    go_idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_bypass();
    test_single_play();
    test_back_to_back();
    test_loop();
    test_pause();
    test_restart_sel();
    test_reset_midnote();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
